// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the integer pipeline: control bundle, ALUOp codes,
// register-index width and the datapath width default.
package riscv_pipe_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_IDX_W    = 5;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode from funct fields
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detect: an in-flight load in EX whose rd feeds the ID instruction.
import riscv_pipe_pkg::*;

module hazard_detection_unit (
  input  logic                 ex_mem_read,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  output logic                 hazard
);

  logic rs1_hit, rs2_hit;

  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign rs1_hit = (ex_rd == id_rs1);
  assign rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);
  assign hazard  = ex_mem_read & ex_valid & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating
// stall/flush event counters.
import riscv_pipe_pkg::*;

module id_ex_stage_register #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] IF_ID_RS1,
  input  logic [REG_IDX_W-1:0] IF_ID_RS2,
  input  logic [REG_IDX_W-1:0] IF_ID_Rd,
  input  logic                 ID_UsesRS2,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemtoReg,
  input  logic                 ID_Branch,
  input  logic                 ID_ALUSrc,
  input  logic [1:0]           ID_ALUOp,
  input  logic [3:0]           ID_Funct4,
  input  logic [XLEN-1:0]      ID_ReadData1,
  input  logic [XLEN-1:0]      ID_ReadData2,
  input  logic [XLEN-1:0]      ID_Imm,
  input  logic [XLEN-1:0]      ID_PC,
  input  logic                 Flush,
  output logic [REG_IDX_W-1:0] ID_EX_RS1,
  output logic [REG_IDX_W-1:0] ID_EX_RS2,
  output logic [REG_IDX_W-1:0] ID_EX_Rd,
  output logic                 ID_EX_RegWrite,
  output logic                 ID_EX_MemRead,
  output logic                 ID_EX_MemWrite,
  output logic                 ID_EX_MemtoReg,
  output logic                 ID_EX_Branch,
  output logic                 ID_EX_ALUSrc,
  output logic [1:0]           ID_EX_ALUOp,
  output logic [3:0]           ID_EX_Funct4,
  output logic [XLEN-1:0]      ID_EX_ReadData1,
  output logic [XLEN-1:0]      ID_EX_ReadData2,
  output logic [XLEN-1:0]      ID_EX_Imm,
  output logic [XLEN-1:0]      ID_EX_PC,
  output logic                 ID_EX_Valid,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic [CNT_W-1:0]     Stall_Count,
  output logic [CNT_W-1:0]     Flush_Count
);

  ctrl_t ctrl_d, ctrl_q;
  logic  hazard, stall;

  assign ctrl_d = '{reg_write:  ID_RegWrite,
                    mem_read:   ID_MemRead,
                    mem_write:  ID_MemWrite,
                    mem_to_reg: ID_MemtoReg,
                    branch:     ID_Branch,
                    alu_src:    ID_ALUSrc,
                    alu_op:     ID_ALUOp};

  hazard_detection_unit u_hdu (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_valid    (ID_EX_Valid),
    .ex_rd       (ID_EX_Rd),
    .id_rs1      (IF_ID_RS1),
    .id_rs2      (IF_ID_RS2),
    .id_uses_rs2 (ID_UsesRS2),
    .hazard      (hazard)
  );

  // A flush squashes the dependent instruction anyway, so it must not freeze fetch
  assign stall       = hazard & ~Flush;
  assign PC_Write    = ~stall;
  assign IF_ID_Write = ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q          <= CTRL_BUBBLE;
      ID_EX_RS1       <= '0;
      ID_EX_RS2       <= '0;
      ID_EX_Rd        <= '0;
      ID_EX_Funct4    <= '0;
      ID_EX_ReadData1 <= '0;
      ID_EX_ReadData2 <= '0;
      ID_EX_Imm       <= '0;
      ID_EX_PC        <= '0;
      ID_EX_Valid     <= 1'b0;
      Stall_Count     <= '0;
      Flush_Count     <= '0;
    end else if (Flush || stall) begin
      ctrl_q          <= CTRL_BUBBLE;
      ID_EX_RS1       <= '0;
      ID_EX_RS2       <= '0;
      ID_EX_Rd        <= '0;
      ID_EX_Funct4    <= '0;
      ID_EX_ReadData1 <= '0;
      ID_EX_ReadData2 <= '0;
      ID_EX_Imm       <= '0;
      ID_EX_PC        <= '0;
      ID_EX_Valid     <= 1'b0;
      if (Flush) begin
        if (Flush_Count != '1) Flush_Count <= Flush_Count + CNT_W'(1);
      end else begin
        if (Stall_Count != '1) Stall_Count <= Stall_Count + CNT_W'(1);
      end
    end else begin
      ctrl_q          <= ctrl_d;
      ID_EX_RS1       <= IF_ID_RS1;
      ID_EX_RS2       <= IF_ID_RS2;
      ID_EX_Rd        <= IF_ID_Rd;
      ID_EX_Funct4    <= ID_Funct4;
      ID_EX_ReadData1 <= ID_ReadData1;
      ID_EX_ReadData2 <= ID_ReadData2;
      ID_EX_Imm       <= ID_Imm;
      ID_EX_PC        <= ID_PC;
      ID_EX_Valid     <= 1'b1;
    end
  end

  assign ID_EX_RegWrite = ctrl_q.reg_write;
  assign ID_EX_MemRead  = ctrl_q.mem_read;
  assign ID_EX_MemWrite = ctrl_q.mem_write;
  assign ID_EX_MemtoReg = ctrl_q.mem_to_reg;
  assign ID_EX_Branch   = ctrl_q.branch;
  assign ID_EX_ALUSrc   = ctrl_q.alu_src;
  assign ID_EX_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for id_ex_stage_register: scoreboarded load-use, flush,
// saturation and asynchronous-reset scenarios.
module tb_id_ex_stage_register;

  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] IF_ID_RS1, IF_ID_RS2, IF_ID_Rd;
  logic ID_UsesRS2, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc;
  logic [1:0] ID_ALUOp;
  logic [3:0] ID_Funct4;
  logic [XLEN-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC;
  logic Flush;
  logic [4:0] ID_EX_RS1, ID_EX_RS2, ID_EX_Rd;
  logic ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc;
  logic [1:0] ID_EX_ALUOp;
  logic [3:0] ID_EX_Funct4;
  logic [XLEN-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC;
  logic ID_EX_Valid, PC_Write, IF_ID_Write;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;

  id_ex_stage_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_Rd(IF_ID_Rd),
    .ID_UsesRS2(ID_UsesRS2), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg), .ID_Branch(ID_Branch),
    .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp), .ID_Funct4(ID_Funct4),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .Flush(Flush),
    .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_Funct4(ID_EX_Funct4), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
    .ID_EX_Valid(ID_EX_Valid), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 clk = ~clk;

  // ctrl order: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp}
  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [7:0]      ctrl;
    logic [3:0]      f4;
    logic [XLEN-1:0] rd1, rd2, imm, pc;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference state: what the bench believes the stage currently holds
  logic m_valid, m_mr;
  logic [4:0] m_rd;
  logic [CNT_W-1:0] m_sc, m_fc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] top;
    top = '1;
    return (v == top) ? v : v + 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, "_valid"}, XLEN'(ID_EX_Valid), XLEN'(e.valid));
    chk({tag, "_ctrl"}, XLEN'({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                              ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp}), XLEN'(e.ctrl));
    chk({tag, "_idx"}, XLEN'({ID_EX_RS1, ID_EX_RS2, ID_EX_Rd}), XLEN'({e.rs1, e.rs2, e.rd}));
    chk({tag, "_f4"}, XLEN'(ID_EX_Funct4), XLEN'(e.f4));
    chk({tag, "_rd1"}, ID_EX_ReadData1, e.rd1);
    chk({tag, "_rd2"}, ID_EX_ReadData2, e.rd2);
    chk({tag, "_imm"}, ID_EX_Imm, e.imm);
    chk({tag, "_pc"}, ID_EX_PC, e.pc);
    chk({tag, "_scnt"}, XLEN'(Stall_Count), XLEN'(e.sc));
    chk({tag, "_fcnt"}, XLEN'(Flush_Count), XLEN'(e.fc));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_mr = 1'b0; m_rd = '0; m_sc = '0; m_fc = '0;
    q.delete();
  endtask

  // Drive one ID instruction and push the expected ID/EX contents after the next edge
  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic uses2, mr, rw, fl);
    exp_t e;
    logic hz;
    IF_ID_RS1 = rs1; IF_ID_RS2 = rs2; IF_ID_Rd = rd; ID_UsesRS2 = uses2;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = 1'b0; ID_MemtoReg = mr;
    ID_Branch = 1'b0; ID_ALUSrc = mr; ID_ALUOp = mr ? 2'b00 : 2'b10;
    ID_Funct4 = 4'($urandom);
    ID_ReadData1 = {$urandom, $urandom}; ID_ReadData2 = {$urandom, $urandom};
    ID_Imm = {$urandom, $urandom}; ID_PC = {$urandom, $urandom};
    Flush = fl;
    hz = m_valid && m_mr && (m_rd != 0) && ((m_rd == rs1) || (uses2 && (m_rd == rs2)));
    e = '0;
    e.sc = m_sc; e.fc = m_fc;
    if (fl) e.fc = sat_inc(m_fc);
    else if (hz) e.sc = sat_inc(m_sc);
    else begin
      e.valid = 1'b1; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.ctrl = {rw, mr, 1'b0, mr, 1'b0, mr, ID_ALUOp};
      e.f4 = ID_Funct4; e.rd1 = ID_ReadData1; e.rd2 = ID_ReadData2; e.imm = ID_Imm; e.pc = ID_PC;
    end
    m_valid = e.valid; m_mr = e.ctrl[6]; m_rd = e.rd; m_sc = e.sc; m_fc = e.fc;
    q.push_back(e);
    #1;
  endtask

  task automatic chk_pcw(input string tag, input logic exp);
    chk({tag, "_pcw"}, XLEN'(PC_Write), XLEN'(exp));
    chk({tag, "_ifidw"}, XLEN'(IF_ID_Write), XLEN'(exp));
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (q.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      cmp_out(tag, e);
    end
  endtask

  // one instruction through ID: drive, check fetch-enable, clock, compare
  task automatic issue(input string tag, input logic [4:0] rs1, rs2, rd,
                       input logic uses2, mr, rw, fl, input logic exp_pcw);
    drive(rs1, rs2, rd, uses2, mr, rw, fl);
    chk_pcw(tag, exp_pcw);
    step(tag);
  endtask

  initial begin
    exp_t z;
    z = '0;
    reset_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    cmp_out("reset", z);
    chk_pcw("reset", 1'b1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // ld x5 ; add x6,x5,x7 -> one stall, then add captured
    issue("ld5_a", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("lu_stall", 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("lu_add", 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lu_add_rs1", XLEN'(ID_EX_RS1), XLEN'(5));

    // ld x0 ; add x6,x0,x0 -> no stall
    issue("ld0", 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("x0_add", 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // ld x5 ; addi x6,x8,4 with rs2 field 5 but rs2 unused -> no stall
    issue("ld5_b", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("addi", 5'd8, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // rs2 dependency alone stalls
    issue("ld5_c", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("rs2_stall", 5'd9, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("rs2_add", 5'd9, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // flush concurrent with hazard: flush wins
    issue("ld5_d", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("flush_hz", 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_cnt", XLEN'(Flush_Count), XLEN'(1));

    // further load-use pairs: stall counter saturates at 3 and holds
    for (int i = 0; i < 4; i++) begin
      issue("sat_ld", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      issue("sat_stall", 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("sat_add", 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    chk("sat_hold", XLEN'(Stall_Count), XLEN'(3));

    // reset pulsed between edges while a stall is being requested
    issue("rst_ld", 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_pcw("rst_pre", 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    cmp_out("rst_async", z);
    chk_pcw("rst_async", 1'b1);
    #1 reset_n = 1'b1;
    drive(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_pcw("rst_rel", 1'b1);
    step("rst_add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
ID/EX pipeline register with integrated load-use hazard detection. It is the stage directly upstream of the EX-stage forwarding logic. It supplies the registered rs1/rs2 indices, Rd, RegWrite, operands and controls that forwarding and the ALU consume. It also stalls PC/IF-ID on a load-use hazard, inserts bubbles on stall or branch flush, and keeps saturating stall/flush event counters for performance debug.

Parameters:
XLEN, 64, datapath width of operands, immediate and PC
CNT_W, 16, width of each saturating event counter

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
IF_ID_RS1  input  5  rs1 index of instruction in ID
IF_ID_RS2  input  5  rs2 index of instruction in ID
IF_ID_Rd  input  5  rd index of instruction in ID
ID_UsesRS2  input  1  ID instruction reads rs2 (R/S/B types)
ID_RegWrite  input  1  control
ID_MemRead  input  1  control
ID_MemWrite  input  1  control
ID_MemtoReg  input  1  control
ID_Branch  input  1  control
ID_ALUSrc  input  1  control
ID_ALUOp  input  2  control
ID_Funct4  input  4  {funct7[5], funct3}
ID_ReadData1  input  XLEN  register file rs1 value
ID_ReadData2  input  XLEN  register file rs2 value
ID_Imm  input  XLEN  sign-extended immediate
ID_PC  input  XLEN  PC of ID instruction
Flush  input  1  taken branch resolved downstream; squash ID
ID_EX_*  output  matching  registered copies of every ID input above (RS1, RS2, Rd, controls, Funct4, data, Imm, PC)
ID_EX_Valid  output  1  0 when the stage holds a bubble
PC_Write  output  1  combinational; 0 freezes PC
IF_ID_Write  output  1  combinational; 0 freezes IF/ID
Stall_Count  output  CNT_W  load-use bubbles inserted
Flush_Count  output  CNT_W  flush bubbles inserted

Behaviour:
- Reset (reset_n low, async): all ID_EX_* outputs 0, ID_EX_Valid 0, both counters 0. PC_Write/IF_ID_Write follow the combinational rule below on the zeroed state (i.e. 1).
- Hazard = ID_EX_MemRead & ID_EX_Valid & (ID_EX_Rd != 0) & ((ID_EX_Rd == IF_ID_RS1) | (ID_UsesRS2 & (ID_EX_Rd == IF_ID_RS2))).
- Stall = Hazard & ~Flush. PC_Write = IF_ID_Write = ~Stall. These are combinational and take effect the same cycle.
- Each rising edge, priority order:
  1. Flush: load bubble. Flush_Count += 1 (saturating).
  2. Stall: load bubble. Stall_Count += 1 (saturating).
  3. Otherwise: capture all ID_* inputs, ID_EX_Valid = 1.
- Bubble: RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp, Rd, RS1, RS2 and Valid all 0. Data/Imm/PC fields are don't-care; the implementation zeroes them.
- Latency: 1 cycle from ID input to ID_EX_* output.
- Stall length is one cycle by construction: the bubble clears ID_EX_MemRead.
- Flush concurrent with hazard: Flush wins. PC_Write = 1, only Flush_Count increments.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall: next state is reset state; no counter increment.

Decomposition:
- Shared package riscv_pipe_pkg:
  - XLEN default
  - ALUOp encodings
  - packed struct ctrl_t (RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp)
  - constant CTRL_BUBBLE = all-zero ctrl_t
- One combinational sub-module, hazard_detection_unit, computes Hazard from the ID_EX_* and IF_ID_* indices. It is reused later for branch-compare hazards in ID.

Test Plan:
- ld x5 then add x6,x5,x7 (RS1=5, UsesRS2=1, RS2=7) -> PC_Write=IF_ID_Write=0 for one cycle; next edge ID_EX_Valid=0, ID_EX_RegWrite=0; Stall_Count=1; following edge add captured with ID_EX_RS1=5.
- ld x0 then add x6,x0,x0 -> no stall; PC_Write stays 1; Stall_Count=0.
- ld x5 then addi x6,x8,4 with RS2 field=5, UsesRS2=0 -> no stall.
- ld x5, add using x5, Flush=1 same cycle -> PC_Write=1, bubble loaded, Flush_Count=1, Stall_Count=0.
- CNT_W=2, five back-to-back load-use pairs -> Stall_Count reaches 3 and holds 3.
- reset_n pulsed low mid-stall (asynchronous, between edges) -> outputs immediately 0, counters 0, PC_Write=1 after release.
